// File: rtl/lsu_mem_master.sv
// Load/store initiator between the execute stage and the data SRAM.
// Takes one request at a time and issues one word-aligned SRAM access for it.
// Load data is lane-extracted and extended before it is returned on the response channel.
//
// Handshake rule for both channels: a transfer happens on a rising clk edge
// where valid and ready are both 1. A valid source holds its payload stable
// until that edge. req_ready_o is a pure function of state, so it never
// depends on req_valid_i.
module lsu_mem_master #(
  parameter int ADDR_LEN = 32,
  parameter int DATA_LEN = 32
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_we_i,
  input  logic [ADDR_LEN-1:0] req_addr_i,
  input  logic [DATA_LEN-1:0] req_wdata_i,
  input  logic [1:0]          req_size_i,
  input  logic                req_unsigned_i,
  output logic                resp_valid_o,
  input  logic                resp_ready_i,
  output logic [DATA_LEN-1:0] resp_rdata_o,
  output logic                resp_err_o,
  output logic                mem_ren_o,
  output logic [ADDR_LEN-1:0] mem_raddr_o,
  output logic                mem_wen_o,
  output logic [ADDR_LEN-1:0] mem_waddr_o,
  output logic [DATA_LEN-1:0] mem_wdata_o,
  output logic [7:0]          mem_wmask_o,
  input  logic [DATA_LEN-1:0] mem_rdata_i,
  output logic [2:0]          dbg_state_o
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_WAIT  = 3'd2,
    WR_ISSUE = 3'd3,
    RESP     = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          off_q, off_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic                err_q, err_d;
  logic [DATA_LEN-1:0] rdata_q, rdata_d;
  logic                mem_ren_q, mem_ren_d;
  logic                mem_wen_q, mem_wen_d;
  logic [ADDR_LEN-1:0] mem_raddr_q, mem_raddr_d;
  logic [ADDR_LEN-1:0] mem_waddr_q, mem_waddr_d;
  logic [DATA_LEN-1:0] mem_wdata_q, mem_wdata_d;
  logic [7:0]          mem_wmask_q, mem_wmask_d;

  logic                req_accept;
  logic                req_misaligned;
  logic [7:0]          lane_mask;
  logic [ADDR_LEN-1:0] word_addr;
  logic [7:0]          byte_sel;
  logic [15:0]         half_sel;
  logic [DATA_LEN-1:0] load_ext;

  // Request decode: alignment check, byte-lane mask and word address of the incoming request
  always_comb begin
    req_accept = req_valid_i && (state_q == IDLE);
    word_addr  = {req_addr_i[ADDR_LEN-1:2], 2'b00};
    case (req_size_i)
      2'd0:    req_misaligned = 1'b0;
      2'd1:    req_misaligned = req_addr_i[0];
      2'd2:    req_misaligned = |req_addr_i[1:0];
      default: req_misaligned = 1'b1;
    endcase
    case (req_size_i)
      2'd0:    lane_mask = 8'h01 << req_addr_i[1:0];
      2'd1:    lane_mask = 8'h03 << req_addr_i[1:0];
      default: lane_mask = 8'h0F;
    endcase
  end

  // Load extraction from the SRAM word that is valid during RD_WAIT
  always_comb begin
    byte_sel = mem_rdata_i[{off_q, 3'b000} +: 8];
    half_sel = mem_rdata_i[{off_q[1], 4'b0000} +: 16];
    case (size_q)
      2'd0:    load_ext = uns_q ? {{(DATA_LEN-8){1'b0}}, byte_sel}
                                : {{(DATA_LEN-8){byte_sel[7]}}, byte_sel};
      2'd1:    load_ext = uns_q ? {{(DATA_LEN-16){1'b0}}, half_sel}
                                : {{(DATA_LEN-16){half_sel[15]}}, half_sel};
      default: load_ext = mem_rdata_i;
    endcase
  end

  // State register plus request/response and SRAM-facing registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      off_q       <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      mem_ren_q   <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_raddr_q <= '0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
    end else begin
      state_q     <= state_d;
      off_q       <= off_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      mem_ren_q   <= mem_ren_d;
      mem_wen_q   <= mem_wen_d;
      mem_raddr_q <= mem_raddr_d;
      mem_waddr_q <= mem_waddr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
    end
  end

  // Next-state logic; a completed response always passes through IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          if (req_misaligned) state_d = RESP;
          else if (req_we_i)  state_d = WR_ISSUE;
          else                state_d = RD_ISSUE;
        end
      end
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT:  state_d = RESP;
      WR_ISSUE: state_d = RESP;
      RESP:     if (resp_ready_i) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Register updates. Strobes are loaded on the edge that enters an issue state,
  // so each strobe is high for exactly that state.
  always_comb begin
    off_d       = off_q;
    size_d      = size_q;
    uns_d       = uns_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    mem_ren_d   = 1'b0;
    mem_wen_d   = 1'b0;
    mem_wmask_d = 8'h00;
    mem_raddr_d = mem_raddr_q;
    mem_waddr_d = mem_waddr_q;
    mem_wdata_d = mem_wdata_q;
    if (req_accept) begin
      off_d   = req_addr_i[1:0];
      size_d  = req_size_i;
      uns_d   = req_unsigned_i;
      err_d   = req_misaligned;
      rdata_d = '0;
      if (!req_misaligned) begin
        if (req_we_i) begin
          mem_wen_d   = 1'b1;
          mem_waddr_d = word_addr;
          mem_wdata_d = req_wdata_i << {req_addr_i[1:0], 3'b000};
          mem_wmask_d = lane_mask;
        end else begin
          mem_ren_d   = 1'b1;
          mem_raddr_d = word_addr;
        end
      end
    end
    if (state_q == RD_WAIT) rdata_d = load_ext;
  end

  // Output decode: handshake flags from state, everything else straight from flops
  always_comb begin
    req_ready_o  = (state_q == IDLE);
    resp_valid_o = (state_q == RESP);
    resp_rdata_o = rdata_q;
    resp_err_o   = err_q;
    mem_ren_o    = mem_ren_q;
    mem_raddr_o  = mem_raddr_q;
    mem_wen_o    = mem_wen_q;
    mem_waddr_o  = mem_waddr_q;
    mem_wdata_o  = mem_wdata_q;
    mem_wmask_o  = mem_wmask_q;
    dbg_state_o  = state_q;
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: a behavioural SRAM with a registered read port,
// a reference memory/extension model feeding an expected-response queue,
// and one task per feature.
module tb_lsu_mem_master;

  localparam int AW = 32;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  logic          req_valid_i    = 1'b0;
  logic          req_ready_o;
  logic          req_we_i       = 1'b0;
  logic [AW-1:0] req_addr_i     = '0;
  logic [DW-1:0] req_wdata_i    = '0;
  logic [1:0]    req_size_i     = '0;
  logic          req_unsigned_i = 1'b0;
  logic          resp_valid_o;
  logic          resp_ready_i   = 1'b1;
  logic [DW-1:0] resp_rdata_o;
  logic          resp_err_o;
  logic          mem_ren_o;
  logic [AW-1:0] mem_raddr_o;
  logic          mem_wen_o;
  logic [AW-1:0] mem_waddr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [7:0]    mem_wmask_o;
  logic [DW-1:0] mem_rdata_i    = '0;
  logic [2:0]    dbg_state_o;

  lsu_mem_master #(.ADDR_LEN(AW), .DATA_LEN(DW)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_size_i(req_size_i),
    .req_unsigned_i(req_unsigned_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
    .mem_ren_o(mem_ren_o), .mem_raddr_o(mem_raddr_o),
    .mem_wen_o(mem_wen_o), .mem_waddr_o(mem_waddr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o),
    .mem_rdata_i(mem_rdata_i), .dbg_state_o(dbg_state_o)
  );

  // ---------------- SRAM model (registered read, zero when idle) ----------------
  logic [31:0] sram    [logic [29:0]];
  logic [31:0] ref_mem [logic [29:0]];
  logic [31:0] sram_w;

  function automatic logic [31:0] sram_word(input logic [29:0] idx);
    if (sram.exists(idx)) return sram[idx];
    return 32'h0;
  endfunction

  function automatic logic [31:0] ref_word(input logic [29:0] idx);
    if (ref_mem.exists(idx)) return ref_mem[idx];
    return 32'h0;
  endfunction

  always @(posedge clk) begin
    if (mem_ren_o) mem_rdata_i <= sram_word(mem_raddr_o[31:2]);
    else           mem_rdata_i <= '0;
    if (mem_wen_o) begin
      sram_w = sram_word(mem_waddr_o[31:2]);
      for (int b = 0; b < 4; b++)
        if (mem_wmask_o[b]) sram_w[8*b +: 8] = mem_wdata_o[8*b +: 8];
      sram[mem_waddr_o[31:2]] = sram_w;
    end
  end

  // ---------------- scoreboard ----------------
  logic [DW:0] exp_q[$];   // {err, rdata}
  int total = 0;
  int bad   = 0;

  // observations from the most recent request
  logic          obs_timeout;
  int            obs_lat, ren_cnt, wen_cnt, stray_cnt, hold_bad;
  logic [AW-1:0] obs_raddr, obs_waddr;
  logic [DW-1:0] obs_wdata, obs_rdata;
  logic [7:0]    obs_wmask;
  logic          obs_err, post_ok;

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] off,
                                             input logic [1:0] size, input logic uns);
    logic [31:0] s;
    s = w >> (8 * off);
    case (size)
      2'd0:    return uns ? {24'h0, s[7:0]}  : {{24{s[7]}}, s[7:0]};
      2'd1:    return uns ? {16'h0, s[15:0]} : {{16{s[15]}}, s[15:0]};
      default: return w;
    endcase
  endfunction

  // ---------------- driver ----------------
  task automatic send_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] size, input logic uns, input int hold);
    int          wait_cyc;
    int          nb;
    logic [1:0]  off;
    logic [29:0] idx;
    logic [31:0] w;
    logic [31:0] exp_rd;
    logic        exp_err;
    off     = addr[1:0];
    idx     = addr[31:2];
    nb      = 1 << size;
    exp_err = (size == 2'd3) || ((addr % nb) != 0);
    exp_rd  = '0;
    if (!exp_err && !we) exp_rd = model_load(ref_word(idx), off, size, uns);
    if (!exp_err && we) begin
      w = ref_word(idx);
      for (int i = 0; i < nb; i++) w[8*(off+i) +: 8] = wdata[8*i +: 8];
      ref_mem[idx] = w;
    end
    exp_q.push_back({exp_err, exp_rd});

    obs_timeout = 1'b0; obs_lat = 0; ren_cnt = 0; wen_cnt = 0; stray_cnt = 0; hold_bad = 0;
    obs_raddr = '0; obs_waddr = '0; obs_wdata = '0; obs_wmask = '0;
    obs_rdata = '0; obs_err = 1'b0; post_ok = 1'b0;

    @(negedge clk);
    req_valid_i = 1'b1; req_we_i = we; req_addr_i = addr; req_wdata_i = wdata;
    req_size_i = size; req_unsigned_i = uns;
    wait_cyc = 0;
    while (!req_ready_o && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (!req_ready_o) begin
      obs_timeout = 1'b1;
      req_valid_i = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid_i = 1'b0;
    obs_lat = 1;
    forever begin
      if (mem_ren_o) begin ren_cnt++; obs_raddr = mem_raddr_o; end
      if (mem_wen_o) begin
        wen_cnt++; obs_waddr = mem_waddr_o; obs_wdata = mem_wdata_o; obs_wmask = mem_wmask_o;
      end
      if (!mem_wen_o && mem_wmask_o != 8'h00) stray_cnt++;
      if (resp_valid_o || obs_lat >= 10) break;
      @(negedge clk);
      obs_lat++;
    end
    if (!resp_valid_o) begin
      obs_timeout = 1'b1;
      return;
    end
    obs_rdata = resp_rdata_o;
    obs_err   = resp_err_o;
    if (hold > 0) begin
      resp_ready_i = 1'b0;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (!resp_valid_o || resp_rdata_o !== obs_rdata || resp_err_o !== obs_err || req_ready_o)
          hold_bad++;
      end
      resp_ready_i = 1'b1;
    end
    @(negedge clk);
    post_ok = req_ready_o && !resp_valid_o;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1 rstn = 1'b0;
    #2;
    total++; if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0) begin bad++;
      $display("FAIL reset_hs ready=%0b valid=%0b want ready=1 valid=0", req_ready_o, resp_valid_o); end
    total++; if ({mem_ren_o, mem_wen_o, mem_wmask_o} !== 10'h0) begin bad++;
      $display("FAIL reset_strobes got=%h want=0", {mem_ren_o, mem_wen_o, mem_wmask_o}); end
    total++; if ({mem_raddr_o, mem_waddr_o, mem_wdata_o} !== 96'h0) begin bad++;
      $display("FAIL reset_regs got=%h want=0", {mem_raddr_o, mem_waddr_o, mem_wdata_o}); end
    total++; if ({resp_err_o, resp_rdata_o} !== 33'h0) begin bad++;
      $display("FAIL reset_resp got=%h want=0", {resp_err_o, resp_rdata_o}); end
    total++; if (dbg_state_o !== 3'd0) begin bad++;
      $display("FAIL reset_state got=%0d want=0", dbg_state_o); end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_load();
    logic [31:0] a_t [4] = '{32'h8000_0001, 32'h8000_0001, 32'h8000_0002, 32'h8000_0000};
    logic [1:0]  s_t [4] = '{2'd0, 2'd0, 2'd1, 2'd2};
    logic        u_t [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [32:0] exp;
    for (int i = 0; i < 4; i++) begin
      send_req(1'b0, a_t[i], 32'h0, s_t[i], u_t[i], 0);
      exp = exp_q.pop_front();
      total++; if (obs_timeout || {obs_err, obs_rdata} !== exp) begin bad++;
        $display("FAIL load_resp[%0d] got=%h want=%h", i, {obs_err, obs_rdata}, exp); end
      total++; if (obs_lat !== 3) begin bad++;
        $display("FAIL load_latency[%0d] got=%0d want=3", i, obs_lat); end
      total++; if (ren_cnt !== 1 || wen_cnt !== 0 || obs_raddr !== {a_t[i][31:2], 2'b00}) begin bad++;
        $display("FAIL load_strobe[%0d] ren=%0d wen=%0d raddr=%h want 1 0 %h", i, ren_cnt, wen_cnt,
                 obs_raddr, {a_t[i][31:2], 2'b00}); end
      total++; if (post_ok !== 1'b1) begin bad++;
        $display("FAIL load_post[%0d] got=%0b want=1", i, post_ok); end
    end
  endtask

  task automatic test_store();
    logic [31:0] a_t [2] = '{32'h8000_0003, 32'h8000_0002};
    logic [31:0] d_t [2] = '{32'h0000_00AB, 32'h0000_1234};
    logic [1:0]  s_t [2] = '{2'd0, 2'd1};
    logic [31:0] wd_t[2] = '{32'hAB00_0000, 32'h1234_0000};
    logic [7:0]  m_t [2] = '{8'h08, 8'h0C};
    logic [32:0] exp;
    for (int i = 0; i < 2; i++) begin
      send_req(1'b1, a_t[i], d_t[i], s_t[i], 1'b0, 0);
      exp = exp_q.pop_front();
      total++; if (obs_timeout || {obs_err, obs_rdata} !== exp) begin bad++;
        $display("FAIL store_resp[%0d] got=%h want=%h", i, {obs_err, obs_rdata}, exp); end
      total++; if (obs_lat !== 2) begin bad++;
        $display("FAIL store_latency[%0d] got=%0d want=2", i, obs_lat); end
      total++; if (wen_cnt !== 1 || ren_cnt !== 0 || obs_waddr !== 32'h8000_0000) begin bad++;
        $display("FAIL store_strobe[%0d] wen=%0d ren=%0d waddr=%h want 1 0 80000000", i, wen_cnt,
                 ren_cnt, obs_waddr); end
      total++; if (obs_wdata !== wd_t[i] || obs_wmask !== m_t[i] || stray_cnt !== 0) begin bad++;
        $display("FAIL store_lane[%0d] wdata=%h mask=%h stray=%0d want %h %h 0", i, obs_wdata,
                 obs_wmask, stray_cnt, wd_t[i], m_t[i]); end
    end
    send_req(1'b0, 32'h8000_0000, 32'h0, 2'd2, 1'b0, 0);
    exp = exp_q.pop_front();
    total++; if (obs_timeout || {obs_err, obs_rdata} !== exp || obs_rdata !== 32'h1234_BEEF) begin bad++;
      $display("FAIL store_readback got=%h want=%h (1234beef)", {obs_err, obs_rdata}, exp); end
  endtask

  task automatic test_error();
    logic        w_t [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] a_t [4] = '{32'h8000_0002, 32'h8000_0000, 32'h8000_0001, 32'h8000_0003};
    logic [1:0]  s_t [4] = '{2'd2, 2'd3, 2'd1, 2'd1};
    logic [32:0] exp;
    for (int i = 0; i < 4; i++) begin
      send_req(w_t[i], a_t[i], 32'hFFFF_FFFF, s_t[i], 1'b0, 0);
      exp = exp_q.pop_front();
      total++; if (obs_timeout || {obs_err, obs_rdata} !== exp) begin bad++;
        $display("FAIL err_resp[%0d] got=%h want=%h", i, {obs_err, obs_rdata}, exp); end
      total++; if (obs_lat !== 1) begin bad++;
        $display("FAIL err_latency[%0d] got=%0d want=1", i, obs_lat); end
      total++; if (ren_cnt !== 0 || wen_cnt !== 0 || stray_cnt !== 0) begin bad++;
        $display("FAIL err_no_access[%0d] ren=%0d wen=%0d stray=%0d want 0", i, ren_cnt, wen_cnt,
                 stray_cnt); end
    end
  endtask

  task automatic test_hold();
    logic        w_t [2] = '{1'b0, 1'b0};
    logic [31:0] a_t [2] = '{32'h8000_0000, 32'h8000_0001};
    logic [1:0]  s_t [2] = '{2'd2, 2'd1};
    logic [32:0] exp;
    for (int i = 0; i < 2; i++) begin
      send_req(w_t[i], a_t[i], 32'h0, s_t[i], 1'b0, 5);
      exp = exp_q.pop_front();
      total++; if (obs_timeout || {obs_err, obs_rdata} !== exp) begin bad++;
        $display("FAIL hold_resp[%0d] got=%h want=%h", i, {obs_err, obs_rdata}, exp); end
      total++; if (hold_bad !== 0) begin bad++;
        $display("FAIL hold_stable[%0d] unstable_cycles=%0d want 0", i, hold_bad); end
      total++; if (post_ok !== 1'b1) begin bad++;
        $display("FAIL hold_release[%0d] ready_after=%0b want 1", i, post_ok); end
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    @(negedge clk);
    req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 32'h8000_0000;
    req_size_i = 2'd2; req_unsigned_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid_i = 1'b0;
    total++; if (mem_ren_o !== 1'b1) begin bad++;
      $display("FAIL mid_ren_issue got=%0b want=1", mem_ren_o); end
    #1 rstn = 1'b0;
    #1;
    total++; if (mem_ren_o !== 1'b0 || mem_raddr_o !== 32'h0) begin bad++;
      $display("FAIL mid_ren_drop ren=%0b raddr=%h want 0 0", mem_ren_o, mem_raddr_o); end
    total++; if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0) begin bad++;
      $display("FAIL mid_hs ready=%0b valid=%0b want 1 0", req_ready_o, resp_valid_o); end
    @(negedge clk);
    rstn = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid_o || mem_ren_o || mem_wen_o) seen++;
    end
    total++; if (seen !== 0) begin bad++;
      $display("FAIL mid_no_resp active_cycles=%0d want 0", seen); end
    total++; if (req_ready_o !== 1'b1) begin bad++;
      $display("FAIL mid_ready_after got=%0b want 1", req_ready_o); end
  endtask

  task automatic test_random();
    logic        we, uns;
    logic [31:0] addr, wdata;
    logic [1:0]  size;
    logic [32:0] exp;
    int          exp_lat, nb;
    for (int i = 0; i < 40; i++) begin
      we    = 1'($urandom_range(0, 1));
      uns   = 1'($urandom_range(0, 1));
      size  = 2'($urandom_range(0, 3));
      addr  = 32'h8000_0000 + 32'($urandom_range(0, 15));
      wdata = $urandom;
      send_req(we, addr, wdata, size, uns, $urandom_range(0, 2));
      exp = exp_q.pop_front();
      exp_lat = exp[32] ? 1 : (we ? 2 : 3);
      nb = 1 << size;
      total++; if (obs_timeout || {obs_err, obs_rdata} !== exp || obs_lat !== exp_lat) begin bad++;
        $display("FAIL rand_resp[%0d] got=%h lat=%0d want=%h lat=%0d", i, {obs_err, obs_rdata},
                 obs_lat, exp, exp_lat); end
      if (!exp[32] && we) begin
        total++;
        if (wen_cnt !== 1 || ren_cnt !== 0 || obs_waddr !== {addr[31:2], 2'b00} ||
            obs_wdata !== (wdata << (8 * addr[1:0])) ||
            obs_wmask !== 8'(((1 << nb) - 1) << addr[1:0])) begin bad++;
          $display("FAIL rand_store[%0d] wen=%0d waddr=%h wdata=%h mask=%h", i, wen_cnt, obs_waddr,
                   obs_wdata, obs_wmask); end
      end else if (!exp[32]) begin
        total++;
        if (ren_cnt !== 1 || wen_cnt !== 0 || obs_raddr !== {addr[31:2], 2'b00}) begin bad++;
          $display("FAIL rand_load[%0d] ren=%0d raddr=%h want 1 %h", i, ren_cnt, obs_raddr,
                   {addr[31:2], 2'b00}); end
      end else begin
        total++;
        if (ren_cnt !== 0 || wen_cnt !== 0) begin bad++;
          $display("FAIL rand_err_access[%0d] ren=%0d wen=%0d want 0", i, ren_cnt, wen_cnt); end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    logic [31:0] init_addr;
    init_addr = 32'h8000_0000;
    sram[init_addr[31:2]]    = 32'hDEAD_BEEF;
    ref_mem[init_addr[31:2]] = 32'hDEAD_BEEF;
    test_reset();
    test_load();
    test_store();
    test_error();
    test_hold();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store initiator that drives the DPI-backed data SRAM model from the execute stage.
- Upstream it accepts one memory request at a time over a valid/ready handshake.
- Toward the SRAM it issues word-aligned read and write strobes, lane-shifted write data and byte masks.
- On loads it extracts the addressed byte or halfword from the returned word and sign- or zero-extends it. The result goes back over a valid/ready response channel.

Parameters:
- ADDR_LEN, 32, address width.
- DATA_LEN, 32, data width; the lane logic covers 32 only.

Ports:
- clk  input  1  clock; all state changes on posedge.
- rstn  input  1  asynchronous, active-low reset.
- req_valid_i  input  1  request valid.
- req_ready_o  output  1  request accepted when valid & ready.
- req_we_i  input  1  1 = store, 0 = load.
- req_addr_i  input  ADDR_LEN  byte address.
- req_wdata_i  input  DATA_LEN  store data, right-aligned.
- req_size_i  input  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
- req_unsigned_i  input  1  zero-extend on load.
- resp_valid_o  output  1  response valid.
- resp_ready_i  input  1  response consumed.
- resp_rdata_o  output  DATA_LEN  extended load data; 0 for stores and errors.
- resp_err_o  output  1  misaligned or illegal size; no memory access made.
- mem_ren_o  output  1  SRAM read strobe.
- mem_raddr_o  output  ADDR_LEN  word-aligned read address.
- mem_wen_o  output  1  SRAM write strobe.
- mem_waddr_o  output  ADDR_LEN  word-aligned write address.
- mem_wdata_o  output  DATA_LEN  lane-shifted write data.
- mem_wmask_o  output  8  byte enables; bits[7:4] always 0.
- mem_rdata_i  input  DATA_LEN  SRAM registered read data.

Behaviour:
- Reset is asynchronous and active-low, as decided. While rstn = 0:
  - state = IDLE;
  - req_ready_o = 1; resp_valid_o = 0;
  - mem_ren_o = 0, mem_wen_o = 0, mem_wmask_o = 0;
  - all address/data registers are 0.
- Reset mid-operation drops the strobes immediately and discards the request. No response is produced.
- All mem_* outputs are driven from registers.
- FSM states: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, RESP.
- IDLE:
  - req_ready_o = 1; all other states hold it at 0.
  - On accept, latch addr, wdata, size, unsigned and we.
  - Misaligned request → RESP with err = 1. Misaligned means size 1 with addr[0] = 1, size 2 with addr[1:0] ≠ 0, or size 3.
  - Aligned load → RD_ISSUE. Aligned store → WR_ISSUE.
- RD_ISSUE:
  - mem_ren_o = 1 for exactly one cycle.
  - mem_raddr_o = {addr[ADDR_LEN-1:2], 2'b00}.
  - Next state → RD_WAIT.
- RD_WAIT:
  - mem_rdata_i is valid this cycle, because the SRAM registered it on the RD_ISSUE edge.
  - Capture mem_rdata_i here; the SRAM zeroes its output once the read strobe is low.
  - Extraction, with k = addr[1:0]:
    - byte = mem_rdata_i[8k+7 : 8k];
    - half = mem_rdata_i[16·addr[1]+15 : 16·addr[1]];
    - sign-extend unless unsigned.
  - Next state → RESP.
- WR_ISSUE:
  - mem_wen_o = 1 for exactly one cycle.
  - mem_waddr_o is word-aligned.
  - mem_wdata_o = wdata << 8k.
  - mem_wmask_o: byte 0x01<<k; half 0x03<<k; word 0x0F.
  - Next state → RESP.
- RESP:
  - resp_valid_o = 1; rdata and err are held stable until resp_ready_i.
  - On resp_valid_o & resp_ready_i → IDLE.
  - A new request is never accepted in the same cycle a response completes; IDLE is entered first.
- Outside their issue states, mem_ren_o, mem_wen_o and mem_wmask_o are 0.
- Latency, counted from the accept edge:
  - load response valid 3 cycles later;
  - store response valid 2 cycles later;
  - error response valid 1 cycle later;
  - each case assumes resp_ready_i = 1.
- Throughput: at most one request in flight.
- Addresses wrap naturally; there is no range checking.

Test Plan:
- Reset asserted mid-RD_ISSUE → mem_ren_o falls without waiting for clk; no response; req_ready_o = 1 after release.
- SRAM word 0x80000000 = 0xDEADBEEF; load byte at 0x80000001, signed → mem_ren_o for one cycle with raddr 0x80000000; resp_rdata_o = 0xFFFFFFBE three cycles after accept. The same load with unsigned = 1 gives 0x000000BE.
- Load half at 0x80000002, signed → 0xFFFFDEAD; load word at 0x80000000 → 0xDEADBEEF.
- Store byte 0x000000AB at 0x80000003 → waddr 0x80000000, wdata 0xAB000000, wmask 0x08. Store half 0x1234 at 0x80000002 → wdata 0x12340000, wmask 0x0C. Readback word confirms the merge.
- Load word at 0x80000002 → resp_err_o = 1 one cycle after accept, resp_rdata_o = 0, no mem_ren_o/mem_wen_o pulse. size = 3 gives the same result.
- Hold resp_ready_i = 0 for 5 cycles → resp_valid_o, rdata and err stay stable and req_ready_o stays 0. After resp_ready_i, the next request is accepted one cycle later.
